// File: rtl/beta_pkg.sv
// beta_pkg: shared types and helpers for the beta data-memory responder.
// Holds the responder FSM state encoding, the channel tag for the captured
// transaction, and the latency-counter width helper.
package beta_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Channel of the transaction currently in flight
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } dmem_chan_t;

    // Width of a counter that can hold values 0..lat.
    // The top derives its localparam DMEM_LAT_W from this.
    function automatic int dmem_lat_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/beta_dmem_ram.sv
// beta_dmem_ram: single-port, byte-enabled synchronous word array.
// Write and read share one index; read data is registered and only
// updated when re is high so it holds between reads. Contents are not reset.
module beta_dmem_ram #(
    parameter int DataWidth = 32,
    parameter int MemDepth  = 1024
) (
    input  logic                          clk_i,
    input  logic                          we,
    input  logic                          re,
    input  logic [DataWidth/8-1:0]        be,
    input  logic [$clog2(MemDepth)-1:0]   idx,
    input  logic [DataWidth-1:0]          wdata,
    output logic [DataWidth-1:0]          rdata
);

    localparam int NB = DataWidth / 8;

    logic [DataWidth-1:0] mem_q [MemDepth];
    logic [DataWidth-1:0] rdata_q;

    // Byte-lane writes and registered read port
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/beta_dmem_responder.sv
// beta_dmem_responder: data-memory responder for the core's split
// read/write data port. One transaction in flight; write wins over read
// when both request in the same IDLE cycle; valid pulses Latency cycles
// after the accept edge. Optional macro BETA_DMEM_ERR_EN adds out-of-range
// detection and the rdata_err_o / wdata_err_o ports.
module beta_dmem_responder
    import beta_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int MemDepth     = 1024,
    parameter int Latency      = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rdata_req_i,
    input  logic [AddressWidth-1:0]  rdata_addr_i,
    input  logic [DataWidth/8-1:0]   rdata_strb_i,
    output logic                     rdata_ready_o,
    output logic                     rdata_valid_o,
    output logic [DataWidth-1:0]     rdata_data_o,
    input  logic                     wdata_req_i,
    input  logic [AddressWidth-1:0]  wdata_addr_i,
    input  logic [DataWidth/8-1:0]   wdata_strb_i,
    input  logic [DataWidth-1:0]     wdata_data_i,
    output logic                     wdata_ready_o,
    output logic                     wdata_valid_o
`ifdef BETA_DMEM_ERR_EN
    ,
    output logic                     rdata_err_o,
    output logic                     wdata_err_o
`endif
);

    localparam int NB         = DataWidth / 8;
    localparam int IDX_W      = $clog2(MemDepth);
    localparam int DMEM_LAT_W = dmem_lat_w(Latency);
    localparam logic [DMEM_LAT_W-1:0] LAT_LOAD = DMEM_LAT_W'(Latency - 1);
    localparam logic [DMEM_LAT_W-1:0] LAT_ONE  = DMEM_LAT_W'(1);

    dmem_state_t            state_q,  state_d;
    dmem_chan_t             chan_q,   chan_d;
    logic [DMEM_LAT_W-1:0]  cnt_q,    cnt_d;
    logic [NB-1:0]          strb_q,   strb_d;
    logic                   oor_q,    oor_d;
    logic                   rvalid_q, rvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic [DataWidth-1:0]   rhold_q,  rhold_d;

    logic                     wr_acc;
    logic                     rd_acc;
    logic [AddressWidth-1:0]  acc_addr;
    logic [NB-1:0]            acc_strb;
    logic                     acc_oor;
    logic [DataWidth-1:0]     ram_rdata;
    logic [DataWidth-1:0]     rd_mask;
    logic [DataWidth-1:0]     rd_masked;

    // Accept decode: ready is combinational from req and state; reset forces it low
    assign wr_acc   = (state_q == IDLE) && wdata_req_i && !rst_i;
    assign rd_acc   = (state_q == IDLE) && rdata_req_i && !wdata_req_i && !rst_i;
    assign acc_addr = wr_acc ? wdata_addr_i : rdata_addr_i;
    assign acc_strb = wr_acc ? wdata_strb_i : rdata_strb_i;

`ifdef BETA_DMEM_ERR_EN
    // Any address bit above the word index makes the access out of range
    assign acc_oor = |(acc_addr >> (IDX_W + 2));
`else
    // Upper address bits are ignored; the address wraps over the array
    assign acc_oor = 1'b0;
`endif

    beta_dmem_ram #(
        .DataWidth (DataWidth),
        .MemDepth  (MemDepth)
    ) u_ram (
        .clk_i (clk_i),
        .we    (wr_acc && !acc_oor),
        .re    (rd_acc),
        .be    (wdata_strb_i),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (wdata_data_i),
        .rdata (ram_rdata)
    );

    // Expand the captured read strobe into a bit mask; out-of-range reads return zero
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_mask
            assign rd_mask[gi*8 +: 8] = {8{strb_q[gi] && !oor_q}};
        end
    endgenerate

    assign rd_masked = ram_rdata & rd_mask;

    // Next-state logic for the FSM and its registered response outputs
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        strb_d   = strb_q;
        oor_d    = oor_q;
        rvalid_d = 1'b0;
        wvalid_d = 1'b0;
        rhold_d  = rvalid_q ? rd_masked : rhold_q;
        case (state_q)
            IDLE: begin
                if (wr_acc || rd_acc) begin
                    chan_d = wr_acc ? WRITE : READ;
                    strb_d = acc_strb;
                    oor_d  = acc_oor;
                    cnt_d  = LAT_LOAD;
                    if (Latency == 1) begin
                        state_d  = RESP;
                        rvalid_d = rd_acc;
                        wvalid_d = wr_acc;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_ONE;
                if (cnt_q == LAT_ONE) begin
                    state_d  = RESP;
                    rvalid_d = (chan_q == READ);
                    wvalid_d = (chan_q == WRITE);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any pending response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            chan_q   <= READ;
            cnt_q    <= '0;
            strb_q   <= '0;
            oor_q    <= 1'b0;
            rvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            rhold_q  <= '0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            strb_q   <= strb_d;
            oor_q    <= oor_d;
            rvalid_q <= rvalid_d;
            wvalid_q <= wvalid_d;
            rhold_q  <= rhold_d;
        end
    end

    assign rdata_ready_o = rd_acc;
    assign wdata_ready_o = wr_acc;
    assign rdata_valid_o = rvalid_q;
    assign wdata_valid_o = wvalid_q;
    // Fresh masked data during the response cycle, held value afterwards
    assign rdata_data_o  = rvalid_q ? rd_masked : rhold_q;

`ifdef BETA_DMEM_ERR_EN
    assign rdata_err_o = rvalid_q && oor_q;
    assign wdata_err_o = wvalid_q && oor_q;
`endif

    // Byte-offset bits never select anything; upper bits only matter for error detection
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rdata_addr_i[1:0], wdata_addr_i[1:0],
                                acc_addr[AddressWidth-1:IDX_W+2]};

endmodule

// File: tb/tb_beta_dmem_responder.sv
// Testbench for beta_dmem_responder: two instances (Latency 1 and 4),
// directed vectors, scoreboard queue filled by stimulus and drained by a
// monitor on every valid pulse. Build with +define+BETA_DMEM_ERR_EN to
// also exercise the out-of-range error path.
module tb_beta_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rreq   [2];
    logic [31:0] raddr  [2];
    logic [3:0]  rstrb  [2];
    logic        rready [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        wreq   [2];
    logic [31:0] waddr  [2];
    logic [3:0]  wstrb  [2];
    logic [31:0] wdat   [2];
    logic        wready [2];
    logic        wvalid [2];
`ifdef BETA_DMEM_ERR_EN
    logic        rerr   [2];
    logic        werr   [2];
`endif

    always #5 clk = ~clk;

    beta_dmem_responder #(.Latency(1)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .rdata_req_i(rreq[0]), .rdata_addr_i(raddr[0]), .rdata_strb_i(rstrb[0]),
        .rdata_ready_o(rready[0]), .rdata_valid_o(rvalid[0]), .rdata_data_o(rdata[0]),
        .wdata_req_i(wreq[0]), .wdata_addr_i(waddr[0]), .wdata_strb_i(wstrb[0]),
        .wdata_data_i(wdat[0]), .wdata_ready_o(wready[0]), .wdata_valid_o(wvalid[0])
`ifdef BETA_DMEM_ERR_EN
        , .rdata_err_o(rerr[0]), .wdata_err_o(werr[0])
`endif
    );

    beta_dmem_responder #(.Latency(4)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .rdata_req_i(rreq[1]), .rdata_addr_i(raddr[1]), .rdata_strb_i(rstrb[1]),
        .rdata_ready_o(rready[1]), .rdata_valid_o(rvalid[1]), .rdata_data_o(rdata[1]),
        .wdata_req_i(wreq[1]), .wdata_addr_i(waddr[1]), .wdata_strb_i(wstrb[1]),
        .wdata_data_i(wdat[1]), .wdata_ready_o(wready[1]), .wdata_valid_o(wvalid[1])
`ifdef BETA_DMEM_ERR_EN
        , .rdata_err_o(rerr[1]), .wdata_err_o(werr[1])
`endif
    );

    typedef struct {
        int          inst;
        bit          wr;
        logic [31:0] data;
        int          cyc;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int inst);
        return (inst == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rvalid[i] || wvalid[i]) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid: inst %0d rvalid %b wvalid %b at cycle %0d with nothing pending",
                             i, rvalid[i], wvalid[i], cyc);
                end else begin
                    exp_t e;
                    bit   ok;
                    e  = sb.pop_front();
                    ok = (e.inst == i) && (e.wr == wvalid[i]) && (rvalid[i] != wvalid[i])
                         && (e.cyc == cyc) && (e.wr || (rdata[i] === e.data));
`ifdef BETA_DMEM_ERR_EN
                    ok = ok && ((e.wr ? werr[i] : rerr[i]) == e.err);
`endif
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL resp: inst %0d wr %b data %h cycle %0d; expected inst %0d wr %b data %h cycle %0d err %b",
                                 i, wvalid[i], rdata[i], cyc, e.inst, e.wr, e.data, e.cyc, e.err);
                    end else begin
                        $display("ok   resp: inst %0d wr %b data %h cycle %0d", i, wvalid[i], rdata[i], cyc);
                    end
                end
            end
        end
    end

    // Issue one request starting at a negedge; returns the cycle in which ready was seen
    task automatic do_req(input int inst, input bit wr, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] data,
                          input logic [31:0] exp, input bit exp_err, input bit push,
                          output int rc);
        bit got;
        exp_t e;
        got = 0;
        rc  = -1;
        if (wr) begin
            wreq[inst] = 1'b1; waddr[inst] = addr; wstrb[inst] = strb; wdat[inst] = data;
        end else begin
            rreq[inst] = 1'b1; raddr[inst] = addr; rstrb[inst] = strb;
        end
        for (int k = 0; k < 50; k++) begin
            #1;
            if (wr ? wready[inst] : rready[inst]) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: inst %0d wr %b addr %h never accepted", inst, wr, addr);
        end else begin
            rc = cyc;
            if (push) begin
                e.inst = inst; e.wr = wr; e.data = exp; e.cyc = cyc + lat_of(inst); e.err = exp_err;
                sb.push_back(e);
            end
            @(posedge clk);
        end
        @(negedge clk);
        if (wr) wreq[inst] = 1'b0;
        else    rreq[inst] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        int c, c1, c2, start;
        for (int i = 0; i < 2; i++) begin
            rreq[i] = 0; raddr[i] = 0; rstrb[i] = 0;
            wreq[i] = 0; waddr[i] = 0; wstrb[i] = 0; wdat[i] = 0;
        end
        rst = 1'b1;
        wreq[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wready_forced_low", wready[0], 0);
        chk("reset_rvalid0", rvalid[0], 0);
        chk("reset_wvalid0", wvalid[0], 0);
        chk("reset_rdata0", rdata[0], 0);
        chk("reset_rready1", rready[1], 0);
        chk("reset_rdata1", rdata[1], 0);
        wreq[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Latency 1: write/read back, byte strobes, zero strobes
        do_req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 1, c);
        do_req(0, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0, 1, c);
        do_req(0, 1, 32'h10, 4'h5, 32'h11223344, 0, 0, 1, c);
        drain();
        #1;
        chk("rdata_holds_after_write", rdata[0], 32'hDEADBEEF);
        @(negedge clk);
        do_req(0, 0, 32'h10, 4'hF, 0, 32'hDE22BE44, 0, 1, c);
        do_req(0, 0, 32'h10, 4'h3, 0, 32'h0000BE44, 0, 1, c);
        do_req(0, 0, 32'h10, 4'h0, 0, 32'h00000000, 0, 1, c);
        do_req(0, 1, 32'h10, 4'h0, 32'hFFFFFFFF, 0, 0, 1, c);
        do_req(0, 0, 32'h12, 4'hF, 0, 32'hDE22BE44, 0, 1, c);
        drain();

        // Simultaneous read and write to 0x20: write first, read after RESP
        @(negedge clk);
        wreq[0] = 1; waddr[0] = 32'h20; wstrb[0] = 4'hF; wdat[0] = 32'hCAFEF00D;
        rreq[0] = 1; raddr[0] = 32'h20; rstrb[0] = 4'hF;
        #1;
        chk("simul_wready_first", wready[0], 1);
        chk("simul_rready_blocked", rready[0], 0);
        sb.push_back('{inst: 0, wr: 1, data: 0, cyc: cyc + 1, err: 0});
        @(negedge clk);
        wreq[0] = 0;
        #1;
        chk("simul_rready_low_in_resp", rready[0], 0);
        @(negedge clk);
        #1;
        chk("simul_rready_after_resp", rready[0], 1);
        sb.push_back('{inst: 0, wr: 0, data: 32'hCAFEF00D, cyc: cyc + 1, err: 0});
        @(posedge clk);
        @(negedge clk);
        rreq[0] = 0;
        do_req(0, 0, 32'h23, 4'hF, 0, 32'hCAFEF00D, 0, 1, c);
        drain();

        // Latency 4: valid exactly 4 cycles after accept, one transaction per 5 cycles
        do_req(1, 1, 32'h40, 4'hF, 32'h12345678, 0, 0, 1, c1);
        do_req(1, 0, 32'h40, 4'hF, 0, 32'h12345678, 0, 1, c2);
        chk("lat4_accept_spacing", c2 - c1, 5);
        drain();

        // Reset in WAIT: pending read response dropped, outputs zero at once
        do_req(1, 0, 32'h40, 4'hF, 0, 0, 0, 0, c);
        rreq[1] = 1; raddr[1] = 32'h40; rstrb[1] = 4'hF;
        rst = 1'b1;
        #1;
        chk("rst_wait_rready", rready[1], 0);
        chk("rst_wait_rvalid", rvalid[1], 0);
        chk("rst_wait_wvalid", wvalid[1], 0);
        chk("rst_wait_rdata", rdata[1], 0);
        rreq[1] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        start = cyc;
        do_req(1, 0, 32'h40, 4'hF, 0, 32'h12345678, 0, 1, c);
        chk("rst_fsm_idle_accept_cycle", c - start, 0);
        drain();

`ifdef BETA_DMEM_ERR_EN
        // Out-of-range accesses: accepted, flagged, array untouched
        do_req(0, 1, 32'h0, 4'hF, 32'hA5A5A5A5, 0, 0, 1, c);
        do_req(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0, 1, 1, c);
        do_req(0, 0, 32'h0, 4'hF, 0, 32'hA5A5A5A5, 0, 1, c);
        do_req(0, 0, 32'h1000, 4'hF, 0, 32'h0, 1, 1, c);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
